// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_ctrl.sv
// Integer clock divider with ratio handshake; ratio changes land on period boundaries.
// Optional stop/start control via the run port when CLK_DIV_CTRL_DIV_STOP_EN is defined.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DIV_RST = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
`ifdef CLK_DIV_CTRL_DIV_STOP_EN
    input  logic             run,
`endif
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_p,
    output logic             div_en,
    output logic             odd_flag,
    output logic [CNT_W-1:0] cur_div,
    output logic             apply
);

    localparam int unsigned     HALF_W    = CNT_W + 1;
    localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
`ifdef CLK_DIV_CTRL_DIV_STOP_EN
    localparam state_e          RST_STATE = IDLE;
`else
    localparam state_e          RST_STATE = RUN;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cur_div_q, cur_div_d;
    logic [CNT_W-1:0]   pend_div_q, pend_div_d;
    logic               clk_p_q, clk_p_d;
    logic               div_en_q, div_en_d;
    logic               apply_q, apply_d;
    logic               cfg_err_q, cfg_err_d;
    logic               odd_q, odd_d;
    logic               cfg_ready_q, cfg_ready_d;

    logic               run_req;
    logic               hs;
    logic               legal;
    logic               last;
    logic               active_d;
    logic [HALF_W-1:0]  half_d;

`ifdef CLK_DIV_CTRL_DIV_STOP_EN
    assign run_req = run;
`else
    assign run_req = 1'b1;
`endif

    // Next-state, counter and ratio update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        apply_d    = 1'b0;
        cfg_err_d  = 1'b0;

        hs    = cfg_valid && cfg_ready_q;
        legal = (cfg_div >= CNT_W'(MIN_DIV));
        last  = (cnt_q == (cur_div_q - CNT_W'(1)));

        if (hs && !legal) begin
            cfg_err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (hs && legal) begin
                    cur_div_d = cfg_div;
                    apply_d   = 1'b1;
                end
                if (run_req) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = last ? '0 : (cnt_q + CNT_W'(1));
                if (hs && legal) begin
                    pend_div_d = cfg_div;
                    state_d    = PEND;
                end else if (last && !run_req) begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                cnt_d = last ? '0 : (cnt_q + CNT_W'(1));
                if (last) begin
                    cur_div_d  = pend_div_q;
                    pend_div_d = '0;
                    apply_d    = 1'b1;
                    state_d    = run_req ? RUN : IDLE;
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are derived from next-cycle values so the registered copies line up with cnt_q
    always_comb begin
        active_d    = (state_d != IDLE);
        half_d      = (HALF_W'(cur_div_d) + HALF_W'(1)) >> 1;
        clk_p_d     = active_d && (HALF_W'(cnt_d) < half_d);
        div_en_d    = active_d && (cnt_d == (cur_div_d - CNT_W'(1)));
        odd_d       = cur_div_d[0];
        cfg_ready_d = (state_d != PEND);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            cur_div_q   <= DIV_RST_V;
            pend_div_q  <= '0;
            clk_p_q     <= 1'b0;
            div_en_q    <= 1'b0;
            apply_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
            odd_q       <= DIV_RST_V[0];
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_div_q   <= cur_div_d;
            pend_div_q  <= pend_div_d;
            clk_p_q     <= clk_p_d;
            div_en_q    <= div_en_d;
            apply_q     <= apply_d;
            cfg_err_q   <= cfg_err_d;
            odd_q       <= odd_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign clk_p     = clk_p_q;
    assign div_en    = div_en_q;
    assign odd_flag  = odd_q;
    assign cur_div   = cur_div_q;
    assign apply     = apply_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: period-level reference model plus directed literal checks.
module tb_clk_div_ctrl;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       run_drv;
    logic       cfg_ready, cfg_err, clk_p, div_en, odd_flag, apply;
    logic [7:0] cur_div;

    int checks = 0;
    int errors = 0;

    // Reference model: active ratio, position in the period, waiting ratio (0 = none)
    int m_n, m_pos, m_pend;
    bit m_running, m_first, m_apply, m_err;

`ifdef CLK_DIV_CTRL_DIV_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    clk_div_ctrl #(.CNT_W(8), .DIV_RST(5)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
`ifdef CLK_DIV_CTRL_DIV_STOP_EN
        .run       (run_drv),
`endif
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_p     (clk_p),
        .div_en    (div_en),
        .odd_flag  (odd_flag),
        .cur_div   (cur_div),
        .apply     (apply)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n       = 5;
        m_pos     = 0;
        m_pend    = 0;
        m_running = !STOP_EN;
        m_first   = 1'b1;
        m_apply   = 1'b0;
        m_err     = 1'b0;
    endtask

    // Advance the model by one input cycle given the inputs presented in that cycle
    task automatic model_step(input bit v, input int d, input bit r);
        bit hs, ok;
        int pend_old;
        hs       = v && (m_pend == 0);
        ok       = (d >= 2);
        m_err    = hs && !ok;
        m_apply  = 1'b0;
        m_first  = 1'b0;
        if (!m_running) begin
            m_pos = 0;
            if (hs && ok) begin
                m_n     = d;
                m_apply = 1'b1;
            end
            if (r) m_running = 1'b1;
        end else begin
            pend_old = m_pend;
            if (hs && ok) m_pend = d;
            if (m_pos == m_n - 1) begin
                m_pos = 0;
                if (pend_old != 0) begin
                    m_n     = pend_old;
                    m_pend  = 0;
                    m_apply = 1'b1;
                    if (!r) m_running = 1'b0;
                end else if (!r && !(hs && ok)) begin
                    m_running = 1'b0;
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic check_all();
        chk("clk_p",     clk_p,     int'(m_running && !m_first && (m_pos < (m_n + 1) / 2)));
        chk("div_en",    div_en,    int'(m_running && (m_pos == m_n - 1)));
        chk("odd_flag",  odd_flag,  m_n % 2);
        chk("cur_div",   cur_div,   m_n);
        chk("cfg_ready", cfg_ready, int'(m_pend == 0));
        chk("apply",     apply,     int'(m_apply));
        chk("cfg_err",   cfg_err,   int'(m_err));
    endtask

    task automatic step(input bit v, input int d);
        cfg_valid = v;
        cfg_div   = 8'(d);
        model_step(v, d, STOP_EN ? run_drv : 1'b1);
        @(posedge clk_in);
        #1;
        cfg_valid = 1'b0;
        check_all();
    endtask

    task automatic wait_pos(input int p);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            if (m_running && m_pos == p) done = 1'b1;
            else step(1'b0, 0);
        end
        if (!done) chk("wait_pos_timeout", 0, 1);
    endtask

    task automatic wait_apply(output int n_steps);
        n_steps = 0;
        for (int i = 0; i < 600 && !m_apply; i++) begin
            step(1'b0, 0);
            n_steps++;
        end
        if (!m_apply) chk("wait_apply_timeout", 0, 1);
    endtask

    // Sample clk_p/div_en for n cycles starting with the current one, MSB first
    task automatic collect(input int n, output logic [15:0] cv, output logic [15:0] dv);
        cv = '0;
        dv = '0;
        for (int i = 0; i < n; i++) begin
            cv = {cv[14:0], clk_p};
            dv = {dv[14:0], div_en};
            step(1'b0, 0);
        end
    endtask

    initial begin
        logic [15:0] cv, dv;
        int          k, cnt_den, applies;

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        run_drv   = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        model_reset();
        check_all();
        chk("rst_cur_div", cur_div, 5);
        chk("rst_odd", odd_flag, 1);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_clk_p", clk_p, 0);

        // Ratio 5 after reset: 3 high / 2 low, div_en once per period
        wait_pos(4);
        chk("div5_boundary_en", div_en, 1);
        step(1'b0, 0);
        collect(5, cv, dv);
        chk("div5_clk_pattern", int'(cv[4:0]), 5'b11100);
        chk("div5_en_pattern", int'(dv[4:0]), 5'b00001);

        // Ratio 4 accepted at cnt=1: waits for boundary
        wait_pos(1);
        step(1'b1, 4);
        chk("pend_ready_low", cfg_ready, 0);
        chk("pend_keeps_div", cur_div, 5);
        wait_apply(k);
        chk("div4_apply", apply, 1);
        chk("div4_cur", cur_div, 4);
        chk("div4_odd", odd_flag, 0);
        collect(4, cv, dv);
        chk("div4_clk_pattern", int'(cv[3:0]), 4'b1100);
        chk("div4_en_pattern", int'(dv[3:0]), 4'b0001);

        // Illegal ratios 1 and 0
        wait_pos(1);
        step(1'b1, 1);
        chk("err_div1", cfg_err, 1);
        chk("err_div1_cur", cur_div, 4);
        step(1'b1, 0);
        chk("err_div0", cfg_err, 1);
        step(1'b0, 0);
        chk("err_single_pulse", cfg_err, 0);
        wait_pos(3);
        step(1'b0, 0);
        collect(4, cv, dv);
        chk("err_clk_pattern", int'(cv[3:0]), 4'b1100);

        // Accept on the boundary keeps the old ratio one more period
        step(1'b1, 5);
        wait_apply(k);
        wait_pos(4);
        step(1'b1, 7);
        chk("bnd_keep_div", cur_div, 5);
        chk("bnd_ready_low", cfg_ready, 0);
        wait_apply(k);
        chk("bnd_apply_delay", k, 5);
        chk("div7_cur", cur_div, 7);
        collect(7, cv, dv);
        chk("div7_clk_pattern", int'(cv[6:0]), 7'b1111000);
        chk("div7_en_pattern", int'(dv[6:0]), 7'b0000001);

        // Reset during PEND discards the waiting ratio
        wait_pos(1);
        step(1'b1, 3);
        chk("rstpend_ready", cfg_ready, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rstpend_async_div", cur_div, 5);
        @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        model_reset();
        check_all();
        applies = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 0);
            applies += int'(apply);
        end
        chk("rstpend_no_apply", applies, 0);
        chk("rstpend_cur_div", cur_div, 5);

`ifdef CLK_DIV_CTRL_DIV_STOP_EN
        // Dropping run finishes the period, then holds clk_p low in IDLE
        wait_pos(1);
        run_drv = 1'b0;
        cnt_den = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 0);
            cnt_den += int'(div_en);
        end
        chk("stop_den_once", cnt_den, 1);
        chk("stop_clk_low", clk_p, 0);
        step(1'b1, 9);
        chk("idle_apply", apply, 1);
        chk("idle_cur_div", cur_div, 9);
        chk("idle_clk_low", clk_p, 0);
        run_drv = 1'b1;
`else
        cnt_den = 0;
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int sel, d;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       d = 0;
                1:       d = 1;
                2:       d = 2;
                3:       d = ($urandom_range(0, 7) == 0) ? 255 : 3;
                default: d = int'($urandom_range(2, 12));
            endcase
            if (STOP_EN) run_drv = ($urandom_range(0, 9) != 0);
            step($urandom_range(0, 3) == 0, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
